// File: rtl/system_pio_edge_in_if.sv
// Avalon-MM slave register port of the edge-capturing input PIO.
interface system_pio_edge_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/system_pio_edge_in.sv
// Input PIO: synchronised level, edge-capture register (R/W1C) and masked level irq.
// Optional per-bit debouncer is enabled by defining PIO_DEBOUNCE_EN.
module system_pio_edge_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    system_pio_edge_in_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    typedef enum logic [1:0] {ARM0, ARM1, ARM2, RUN} arm_t;

    arm_t             arm_q, arm_d;
    logic             armed;
    logic [WIDTH-1:0] s1, s2, lvl, prev, prev_nxt;
    logic [WIDTH-1:0] irq_mask, edge_capture;
    logic [WIDTH-1:0] rise, fall, det, clr;
    logic             wr;

    always_ff @(posedge clk) begin
        if (reset) arm_q <= ARM0;
        else       arm_q <= arm_d;
    end

    always_comb begin
        arm_d = arm_q;
        armed = 1'b0;
        case (arm_q)
            ARM0:    arm_d = ARM1;
            ARM1:    arm_d = ARM2;
            ARM2:    arm_d = RUN;
            RUN:     armed = 1'b1;
            default: arm_d = ARM0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            prev <= prev_nxt;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    logic [15:0] cnt_q [WIDTH];

    // While arming, lvl loads s2 directly; prev loads the same value so
    // the first armed cycle sees no difference between them.
    assign prev_nxt = armed ? lvl : s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (!armed) begin
                    lvl[i]   <= s2[i];
                    cnt_q[i] <= '0;
                end else if (s2[i] != lvl[i]) begin
                    if (cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                        lvl[i]   <= s2[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 16'd1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end
`else
    assign lvl      = s2;
    assign prev_nxt = lvl;
`endif

    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;

    always_comb begin
        det = '0;
        if (armed) begin
            case (EDGE_TYPE)
                0:       det = rise;
                1:       det = fall;
                default: det = rise | fall;
            endcase
        end
    end

    assign wr  = bus.chipselect & ~bus.write_n;
    assign clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
            edge_capture <= (edge_capture & ~clr) | det;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = lvl;
            2'd2:    bus.readdata[WIDTH-1:0] = irq_mask;
            2'd3:    bus.readdata[WIDTH-1:0] = edge_capture;
            default: bus.readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
